// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin writeback arbiter with a registered register-file write port,
// pending-write scoreboard and operand hazard detection. Define REGFILE_ARB_BYPASS_EN to enable commit bypass.
module regfile_write_arbiter #(
  parameter int NREQ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        issue_en,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        stall,
  output logic [31:0] pending,
  output logic        byp1_hit,
  output logic        byp2_hit
);

  generate
    if (NREQ != 2) begin : g_bad_nreq
      $error("regfile_write_arbiter supports only NREQ == 2");
    end
  endgenerate

  // ptr_q == 0 favours A, ptr_q == 1 favours B when both request.
  logic        ptr_q, ptr_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] pending_q, pending_d;
  logic        grant_a_s, grant_b_s;
  logic        haz1_s, haz2_s, byp1_s, byp2_s;

  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (rst) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else if (a_valid && (!b_valid || (ptr_q == 1'b0))) begin
      grant_a_s = 1'b1;
    end else if (b_valid) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (grant_a_s) begin
      ptr_d     = 1'b1;
      wr_en_d   = (a_rd != 5'd0);
      wr_addr_d = a_rd;
      wr_data_d = a_data;
    end else if (grant_b_s) begin
      ptr_d     = 1'b0;
      wr_en_d   = (b_rd != 5'd0);
      wr_addr_d = b_rd;
      wr_data_d = b_data;
    end else begin
      ptr_d   = ptr_q;
      wr_en_d = 1'b0;
    end
  end

  // Clear on commit first so a same-cycle issue to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_q) begin
      pending_d[wr_addr_q] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (issue_en && (issue_rd != 5'd0)) begin
      pending_d[issue_rd] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
      pending_q <= 32'd0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    haz1_s = (rs1 != 5'd0) && pending_q[rs1];
    haz2_s = (rs2 != 5'd0) && pending_q[rs2];
`ifdef REGFILE_ARB_BYPASS_EN
    byp1_s = wr_en_q && (wr_addr_q != 5'd0) && (wr_addr_q == rs1);
    byp2_s = wr_en_q && (wr_addr_q != 5'd0) && (wr_addr_q == rs2);
`else
    byp1_s = 1'b0;
    byp2_s = 1'b0;
`endif
  end

  assign a_ready  = grant_a_s;
  assign b_ready  = grant_b_s;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign pending  = pending_q;
  assign byp1_hit = byp1_s;
  assign byp2_hit = byp2_s;
  assign stall    = (haz1_s && !byp1_s) || (haz2_s && !byp2_s);

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, fixed number of writeback requesters (A, B); other values unsupported.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports a_valid in 1, a_rd in 5, a_data in 32: requester A writeback request, destination, data.
REQ-005 SHALL have port a_ready  out  1  A request accepted this cycle.
REQ-006 SHALL have ports b_valid in 1, b_rd in 5, b_data in 32, b_ready out 1: requester B, same meaning.
REQ-007 SHALL have ports wr_en out 1, wr_addr out 5, wr_data out 32: register file write port drive.
REQ-008 SHALL have ports issue_en in 1, issue_rd in 5: an instruction issued that will write issue_rd.
REQ-009 SHALL have ports rs1 in 5, rs2 in 5, stall out 1: source operands of the issuing instruction; hazard indication.
REQ-010 SHALL have ports pending out 32 (per-register pending-write bitmap) and byp1_hit out 1, byp2_hit out 1 (bypass indications).

Function
REQ-011 SHALL accept at most one request per cycle; handshake = valid && ready on the rising edge.
REQ-012 SHALL compute a_ready/b_ready combinationally from valids and the priority pointer; a requester SHALL hold valid, rd and data stable until accepted.
REQ-013 SHALL arbitrate round-robin: if only one is valid, grant it; if both are valid, grant the side the pointer names.
REQ-014 SHALL move the pointer to the non-granted side after every grant; no grant leaves it unchanged.
REQ-015 SHALL register the accepted request: wr_en=1, wr_addr=rd, wr_data=data exactly one cycle after acceptance; otherwise wr_en=0.
REQ-016 SHALL accept a request with rd==0 normally (ready, pointer update) but SHALL keep wr_en=0 for it.
REQ-017 SHALL sustain one write per cycle with back-to-back requests; there are no bubbles.
REQ-018 SHALL set pending[issue_rd] on issue_en when issue_rd!=0; pending[0] SHALL read 0 always.
REQ-019 SHALL clear pending[wr_addr] in the cycle wr_en=1.
REQ-020 SHALL give set priority over clear when issue and commit hit the same register in one cycle (bit stays 1).
REQ-021 SHALL drive stall = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]), combinational.
REQ-022 SHALL drive byp1_hit/byp2_hit = 0 when the bypass feature is compiled out.

Reset
REQ-023 SHALL, on rst assertion, immediately clear pending to 0, set wr_en=0, wr_addr=0, wr_data=0 and point priority at A.
REQ-024 SHALL drop any accepted-but-uncommitted write on reset mid-operation; no write is issued after rst deasserts.
REQ-025 SHALL hold a_ready=b_ready=0 while rst is high.

Configuration
REQ-026 SHALL use macro REGFILE_ARB_BYPASS_EN.
REQ-027 SHALL, with the macro defined, set byp1_hit = wr_en && wr_addr!=0 && wr_addr==rs1 (likewise byp2_hit for rs2) and exclude a source from stall when its byp hit is 1.
REQ-028 SHALL, without the macro, tie byp1_hit/byp2_hit to 0 and stall strictly per REQ-021.

Verification
REQ-029 SHALL cover reset then A only: a_valid=1, a_rd=5, a_data=0x1234 -> a_ready=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0x1234.
REQ-030 SHALL cover both valid for 4 cycles from reset -> grants A,B,A,B; wr_en=1 on 4 consecutive cycles.
REQ-031 SHALL cover issue_en, issue_rd=7, then rs1=7 -> stall=1 until the cycle after the rd=7 write commits; pending[7] returns 0.
REQ-032 SHALL cover issue_rd=9 on the same cycle as a commit to 9 -> pending[9]=1 afterwards.
REQ-033 SHALL cover request with a_rd=0 -> a_ready=1, wr_en stays 0, pointer moves to B.
REQ-034 SHALL cover rst pulse the cycle after acceptance -> wr_en never asserts; with REGFILE_ARB_BYPASS_EN, commit to 7 with rs2=7 -> byp2_hit=1, stall=0.
